// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch, data and debug requesters share one
// synchronous memory through a fixed-latency IDLE/ISSUE/WAIT/RESP sequence.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic              d_req,
  input  logic              g_req,
  input  logic              f_we,
  input  logic              d_we,
  input  logic              g_we,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] g_wdata,
  output logic              f_ack,
  output logic              d_ack,
  output logic              g_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {G_NONE = 2'd0, G_FETCH = 2'd1, G_DATA = 2'd2, G_DEBUG = 2'd3} own_t;

  state_t        state, state_n;
  own_t          gnt_q, win;
  logic          we_q;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;

  // A saturated starvation count overrides the normal debug > data > fetch order.
  always_comb begin
    win = G_NONE;
    if (f_req && starve_cnt == SW'(STARVE_LIMIT)) win = G_FETCH;
    else if (g_req)                               win = G_DEBUG;
    else if (d_req)                               win = G_DATA;
    else if (f_req)                               win = G_FETCH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (win != G_NONE) state_n = S_ISSUE;
      S_ISSUE: state_n = (WAIT_CYCLES == 1) ? S_RESP : S_WAIT;
      S_WAIT:  if (wait_cnt <= WW'(1)) state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q      <= G_NONE;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win != G_NONE) begin
            gnt_q    <= win;
            wait_cnt <= WW'(WAIT_CYCLES - 1);
            case (win)
              G_FETCH: begin
                mem_addr <= f_addr;
                we_q     <= f_we;
              end
              G_DATA: begin
                mem_addr  <= d_addr;
                we_q      <= d_we;
                mem_wdata <= d_wdata;
              end
              default: begin
                mem_addr  <= g_addr;
                we_q      <= g_we;
                mem_wdata <= g_wdata;
              end
            endcase
            if (win == G_FETCH)
              starve_cnt <= '0;
            else if (f_req && starve_cnt != SW'(STARVE_LIMIT))
              starve_cnt <= starve_cnt + SW'(1);
            else if (!f_req)
              starve_cnt <= '0;
          end
        end
        S_WAIT: if (wait_cnt != '0) wait_cnt <= wait_cnt - WW'(1);
        S_RESP: gnt_q <= G_NONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy   = (state != S_IDLE);
    mem_en = (state == S_ISSUE);
    mem_we = mem_en & we_q;
    gnt    = gnt_q;
    f_ack  = (state == S_RESP) && (gnt_q == G_FETCH);
    d_ack  = (state == S_RESP) && (gnt_q == G_DATA);
    g_ack  = (state == S_RESP) && (gnt_q == G_DEBUG);
    rdata  = (f_ack | d_ack | g_ack) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter, checked every cycle against a
// transaction-position reference model.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int WC = 3;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Requester index 0 fetch, 1 data, 2 debug; owner code is index + 1.
  logic          req_v   [3];
  logic          we_v    [3];
  logic [AW-1:0] addr_v  [3];
  logic [DW-1:0] wdata_v [3];
  logic [DW-1:0] mem_rdata;

  logic          f_ack, d_ack, g_ack;
  logic [DW-1:0] rdata;
  logic [1:0]    gnt;
  logic          busy, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .f_req(req_v[0]), .d_req(req_v[1]), .g_req(req_v[2]),
    .f_we(we_v[0]), .d_we(we_v[1]), .g_we(we_v[2]),
    .f_addr(addr_v[0]), .d_addr(addr_v[1]), .g_addr(addr_v[2]),
    .d_wdata(wdata_v[1]), .g_wdata(wdata_v[2]),
    .f_ack(f_ack), .d_ack(d_ack), .g_ack(g_ack),
    .rdata(rdata), .gnt(gnt), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Model: m_pos is the cycle offset inside an access (0 idle, 1 issue, WC+1 response).
  int            m_pos, m_own, m_starve;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  int            cyc, n_cmp, n_bad, mode, t_issue, t_ack;
  bit            fixed_rd;
  logic [DW-1:0] fixed_val;
  int            grant_log[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_own = 0; m_starve = 0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic check_outputs();
    bit resp;
    resp = (m_pos == WC + 1);
    check_eq("busy",      64'(busy),      64'(m_pos != 0));
    check_eq("gnt",       64'(gnt),       64'((m_pos != 0) ? m_own : 0));
    check_eq("mem_en",    64'(mem_en),    64'(m_pos == 1));
    check_eq("mem_we",    64'(mem_we),    64'(m_pos == 1 && m_we));
    check_eq("mem_addr",  64'(mem_addr),  64'(m_addr));
    check_eq("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    check_eq("f_ack",     64'(f_ack),     64'(resp && m_own == 1));
    check_eq("d_ack",     64'(d_ack),     64'(resp && m_own == 2));
    check_eq("g_ack",     64'(g_ack),     64'(resp && m_own == 3));
    check_eq("rdata",     64'(rdata),     resp ? 64'(mem_rdata) : 64'(0));
    check_eq("starve",    64'(dut.starve_cnt), 64'(m_starve));
    if (mem_en === 1'b1) begin
      grant_log.push_back(int'(gnt));
      t_issue = cyc;
    end
    if ((f_ack | d_ack | g_ack) === 1'b1) t_ack = cyc;
  endtask

  task automatic drive_inputs();
    for (int unsigned i = 0; i < 3; i++) begin
      if (m_pos == WC + 1 && m_own == int'(i) + 1) req_v[i] = 1'b0;
      if (!req_v[i]) begin
        bit go;
        case (mode)
          1:       go = ($urandom_range(0, 3) == 0);
          2:       go = (i != 2);
          default: go = 1'b0;
        endcase
        if (go) begin
          req_v[i]   = 1'b1;
          addr_v[i]  = AW'($urandom);
          we_v[i]    = (i == 0) ? 1'b0 : 1'($urandom);
          wdata_v[i] = $urandom;
        end
      end
    end
    mem_rdata = fixed_rd ? fixed_val : $urandom;
  endtask

  task automatic model_advance();
    if (!reset) return;
    if (m_pos == 0) begin
      int w;
      w = 0;
      if (req_v[0] && m_starve == SL) w = 1;
      else if (req_v[2])              w = 3;
      else if (req_v[1])              w = 2;
      else if (req_v[0])              w = 1;
      if (w != 0) begin
        m_own  = w;
        m_addr = addr_v[w-1];
        m_we   = we_v[w-1];
        if (w != 1) m_wdata = wdata_v[w-1];
        if (w == 1)        m_starve = 0;
        else if (req_v[0]) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
        else               m_starve = 0;
        m_pos = 1;
      end
    end else if (m_pos == WC + 1) begin
      m_pos = 0;
      m_own = 0;
    end else begin
      m_pos++;
    end
  endtask

  task automatic cycle_start();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic cycle_end();
    drive_inputs();
    model_advance();
  endtask

  task automatic tick();
    cycle_start();
    cycle_end();
  endtask

  initial begin
    int c;
    int exp_order[$];
    for (int unsigned i = 0; i < 3; i++) begin
      req_v[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
    end
    mem_rdata = '0;
    fixed_rd = 1'b0; fixed_val = '0;
    cyc = 0; n_cmp = 0; n_bad = 0; mode = 0; t_issue = -1; t_ack = -1;
    model_reset();

    #1 check_outputs();
    repeat (2) tick();
    cycle_start(); reset = 1'b1; cycle_end();
    repeat (2) tick();

    // Single fetch read with known memory data and latency.
    cycle_start();
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = AW'(32'h10);
    fixed_rd = 1'b1; fixed_val = 32'hDEADBEEF;
    c = cyc;
    cycle_end();
    repeat (WC + 3) tick();
    check_eq("lat_issue", 64'(t_issue), 64'(c + 1));
    check_eq("lat_ack",   64'(t_ack),   64'(c + 1 + WC));
    fixed_rd = 1'b0;

    // Data write.
    cycle_start();
    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = AW'(32'h20); wdata_v[1] = 32'h1234;
    cycle_end();
    repeat (WC + 3) tick();

    // All three together: debug, data, fetch.
    grant_log.delete();
    cycle_start();
    for (int unsigned i = 0; i < 3; i++) begin
      req_v[i] = 1'b1; we_v[i] = 1'b0; addr_v[i] = AW'(32'h100 + i);
    end
    cycle_end();
    repeat (3 * (WC + 2) + 2) tick();
    exp_order = '{3, 2, 1};
    check_eq("prio_count", 64'(grant_log.size()), 64'(3));
    for (int unsigned i = 0; i < 3; i++)
      check_eq("prio_order", 64'((grant_log.size() > i) ? grant_log[i] : 0), 64'(exp_order[i]));

    // Starvation: data re-requests after every ack while fetch waits.
    grant_log.delete();
    mode = 2;
    for (int k = 0; k < 200 && grant_log.size() < 5; k++) tick();
    mode = 0;
    repeat (3 * (WC + 2) + 2) tick();
    exp_order = '{2, 2, 2, 2, 1};
    for (int unsigned i = 0; i < 5; i++)
      check_eq("starve_order", 64'((grant_log.size() > i) ? grant_log[i] : 0), 64'(exp_order[i]));

    // Reset during WAIT of a data read; the read must be reissued afterwards.
    for (int k = 0; k < 40 && (m_pos != 0 || req_v[0] || req_v[1] || req_v[2]); k++) tick();
    cycle_start();
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = AW'(32'h44);
    cycle_end();
    for (int k = 0; k < 20 && m_pos != 2; k++) tick();
    check_eq("reach_wait", 64'(m_pos), 64'(2));
    cycle_start();
    reset = 1'b0;
    model_reset();
    #1 check_outputs();
    cycle_end();
    cycle_start(); reset = 1'b1; cycle_end();
    t_ack = -1;
    c = cyc;
    repeat (WC + 4) tick();
    check_eq("reissue_ack", 64'(t_ack), 64'(c + 1 + WC));

    // Random traffic.
    mode = 1;
    repeat (2000) tick();
    mode = 0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
